tg_pwrseq: RTL and testbench
============================

// Module: tg_pwrseq
// PURPOSE
//  Parametrised LCD timing/output stage between the video timing generator and panel pins.
//  Registers and polarity-adjusts sync/DE/RGB, reduces input colour depth to panel depth,
//  runs a panel power sequence (XSTBY wait, blank frames on power-up and power-down),
//  and drives REV as a frame-toggling inversion signal.
// PARAMETERS
//  P_IN_BIT    8     input colour bits per channel
//  P_OUT_BIT   6     panel colour bits per channel (P_OUT_BIT <= P_IN_BIT)
//  P_WAIT_CNT  6250  clk cycles from pwr_req rise to xstby low (1 ms at 6.25 MHz)
//  P_CNT_BIT   13    wait counter width (2**P_CNT_BIT > P_WAIT_CNT)
//  P_BLANK_FRM 2     blanked frames after xstby low, and before xstby high (1..15)
//  P_VS_INV    1     1: vs_out = ~vs_in, 0: vs_out = vs_in
//  P_HS_INV    1     1: hs_out = ~hs_in, 0: hs_out = hs_in
// PORTS
//  clk        in   1          pixel clock
//  xrst       in   1          async reset, active low
//  pwr_req    in   1          1: power panel up, 0: power panel down
//  rev_en     in   1          1: REV toggles per frame, 0: REV held 0
//  vs_in      in   1          vsync, active high
//  hs_in      in   1          hsync, active high
//  de_in      in   1          data enable
//  r/g/bdata_in  in  P_IN_BIT  pixel data
//  vs_out     out  1          panel vsync
//  hs_out     out  1          panel hsync
//  de_out     out  1          panel DE (gated by sequencer)
//  r/g/bdata_out out P_OUT_BIT panel pixel data
//  xstby      out  1          panel standby, active low
//  rev        out  1          panel inversion control
//  ready      out  1          1 while in ST_RUN
// BEHAVIOUR
//  Reset: vs_out=hs_out=P_*_INV, de_out=0, data=0, xstby=1, rev=0, ready=0, state ST_OFF.
//  Output path: all outputs registered, latency 1 clk from inputs; sync outputs never gated.
//  Frame start (fs): 1-clk pulse on registered rising edge of vs_in (vs_in=1, vs_d=0).
//  FSM:
//   ST_OFF:   xstby=1, blank. pwr_req=1 -> ST_WAIT, cnt=0.
//   ST_WAIT:  cnt+1 per clk; cnt==P_WAIT_CNT-1 -> xstby<=0, ST_BLANK, frm=0.
//             pwr_req=0 -> ST_OFF immediately (xstby stays 1).
//   ST_BLANK: blank; frm+1 on fs; frm==P_BLANK_FRM on fs -> ST_RUN (output starts at that frame).
//             pwr_req=0 -> ST_DOWN, frm=0.
//   ST_RUN:   pass-through, ready=1. pwr_req=0 -> ST_DOWN, frm=0 (blank from next clk).
//   ST_DOWN:  blank; frm+1 on fs; frm==P_BLANK_FRM on fs -> xstby<=1, ST_OFF.
//             pwr_req=1 is ignored until ST_OFF is reached (no abort of power-down).
//  Blank: de_out=0, data_out=0; syncs still pass.
//  Only state changes gate; data already in the 1-clk pipe is not retroactively blanked.
//  rev: toggles on fs when rev_en=1 and xstby=0; forced 0 when rev_en=0 or xstby=1.
//  Wait counter saturates; no wrap. fs coincident with a pwr_req change: pwr_req wins.
//  Async reset mid-sequence returns to ST_OFF with xstby=1 within the reset assertion.
// CONFIGURATION
//  TG_FRC_DITHER_EN defined:
//   Requires P_IN_BIT-P_OUT_BIT==2. Adds 2-bit frame counter (+1 on fs), line parity
//   (toggles on de_in fall, cleared on fs), pixel parity (toggles each de_in clk, cleared
//   when de_in=0). t = (frm[1:0] + {line,pix}) mod 4, f = 2 LSBs of input.
//   out = MSBs + (f > t), saturated at all-ones.
//  Not defined: out = in[P_IN_BIT-1 -: P_OUT_BIT] (plain truncation), no frame/line logic.
// TESTING
//  1 reset, pwr_req=0 for 10000 clk -> xstby=1, de_out=0, data=0, ready=0 throughout.
//  2 pwr_req 0->1 at clk N -> xstby falls exactly at N+6250 (+1 reg); de_out stays 0
//    for 2 fs, first non-zero de_out after 2nd fs; ready=1 from same clk.
//  3 ST_RUN, rgb_in=8'hA7, de_in=1 -> rgb_out=6'h29 1 clk later (macro off);
//    vs_in=1 -> vs_out=0 (P_VS_INV=1).
//  4 pwr_req 1->0 in ST_RUN -> de_out=0 next clk, xstby=1 on 2nd fs after; pwr_req
//    re-asserted during ST_DOWN has no effect until ST_OFF.
//  5 rev_en=1, 4 frames -> rev 0,1,0,1 toggling on each fs; rev_en=0 -> rev=0 next clk.
//  6 TG_FRC_DITHER_EN, constant in=8'h05 (MSB=1,f=1) over 4 frames -> each pixel 6'h02
//    in exactly 1 of 4 frames, else 6'h01; in=8'hFF -> 6'h3F always (saturation).

Source files
------------

// File: rtl/tg_pwrseq_if.sv
// Pixel-stream bundle between the timing generator (master) and the LCD output stage (slave).
// Carries sync/DE/RGB towards the stage and the registered panel-side signals back.
interface tg_pwrseq_if #(
  parameter int unsigned P_IN_BIT  = 8,
  parameter int unsigned P_OUT_BIT = 6
);
  logic                 vs_in;
  logic                 hs_in;
  logic                 de_in;
  logic [P_IN_BIT-1:0]  rdata_in;
  logic [P_IN_BIT-1:0]  gdata_in;
  logic [P_IN_BIT-1:0]  bdata_in;
  logic                 vs_out;
  logic                 hs_out;
  logic                 de_out;
  logic [P_OUT_BIT-1:0] rdata_out;
  logic [P_OUT_BIT-1:0] gdata_out;
  logic [P_OUT_BIT-1:0] bdata_out;

  modport master (
    output vs_in, hs_in, de_in, rdata_in, gdata_in, bdata_in,
    input  vs_out, hs_out, de_out, rdata_out, gdata_out, bdata_out
  );

  modport slave (
    input  vs_in, hs_in, de_in, rdata_in, gdata_in, bdata_in,
    output vs_out, hs_out, de_out, rdata_out, gdata_out, bdata_out
  );
endinterface

// File: rtl/tg_pwrseq.sv
// LCD output stage: registered sync/DE/RGB, colour-depth reduction, panel power sequencing, REV.
// Optional frame-rate-control dithering is enabled by defining TG_FRC_DITHER_EN.
module tg_pwrseq #(
  parameter int unsigned P_IN_BIT    = 8,
  parameter int unsigned P_OUT_BIT   = 6,
  parameter int unsigned P_WAIT_CNT  = 6250,
  parameter int unsigned P_CNT_BIT   = 13,
  parameter int unsigned P_BLANK_FRM = 2,
  parameter int unsigned P_VS_INV    = 1,
  parameter int unsigned P_HS_INV    = 1
) (
  input  logic            clk,
  input  logic            xrst,
  input  logic            pwr_req,
  input  logic            rev_en,
  tg_pwrseq_if.slave      vid,
  output logic            xstby,
  output logic            rev,
  output logic            ready
);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_WAIT,
    ST_BLANK,
    ST_RUN,
    ST_DOWN
  } st_t;

  st_t                  state;
  logic [P_CNT_BIT-1:0] cnt;
  logic [3:0]           frm;
  logic                 vs_d;
  logic                 fs;
  logic                 last_frm;
  logic                 run_nx;
  logic [P_OUT_BIT-1:0] r_conv, g_conv, b_conv;

  assign fs       = vid.vs_in & ~vs_d;
  assign last_frm = ((frm + 4'd1) == 4'(P_BLANK_FRM));

  // Gating follows the state being entered so the registered outputs change on the same edge as the state.
  always_comb begin
    run_nx = 1'b0;
    case (state)
      ST_BLANK: run_nx = pwr_req & fs & last_frm;
      ST_RUN:   run_nx = pwr_req;
      default:  run_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state <= ST_OFF;
      cnt   <= '0;
      frm   <= '0;
      xstby <= 1'b1;
    end else begin
      case (state)
        ST_OFF: begin
          if (pwr_req) begin
            state <= ST_WAIT;
            cnt   <= '0;
          end
        end
        ST_WAIT: begin
          if (!pwr_req) begin
            state <= ST_OFF;
          end else if (cnt == P_CNT_BIT'(P_WAIT_CNT - 1)) begin
            xstby <= 1'b0;
            state <= ST_BLANK;
            frm   <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_BLANK: begin
          if (!pwr_req) begin
            state <= ST_DOWN;
            frm   <= '0;
          end else if (fs) begin
            if (last_frm) state <= ST_RUN;
            else          frm   <= frm + 4'd1;
          end
        end
        ST_RUN: begin
          if (!pwr_req) begin
            state <= ST_DOWN;
            frm   <= '0;
          end
        end
        ST_DOWN: begin
          if (fs) begin
            if (last_frm) begin
              xstby <= 1'b1;
              state <= ST_OFF;
            end else begin
              frm <= frm + 4'd1;
            end
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

`ifdef TG_FRC_DITHER_EN
  logic [1:0] frc_frm;
  logic       line_par;
  logic       pix_par;
  logic       de_d;
  logic [1:0] thr;

  assign thr = frc_frm + {line_par, pix_par};

  function automatic logic [P_OUT_BIT-1:0] frc(input logic [P_IN_BIT-1:0] d, input logic [1:0] t);
    logic [P_OUT_BIT-1:0] m;
    m = d[P_IN_BIT-1 -: P_OUT_BIT];
    if ((d[1:0] > t) && (m != '1)) m = m + P_OUT_BIT'(1);
    return m;
  endfunction

  assign r_conv = frc(vid.rdata_in, thr);
  assign g_conv = frc(vid.gdata_in, thr);
  assign b_conv = frc(vid.bdata_in, thr);

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      frc_frm  <= '0;
      line_par <= 1'b0;
      pix_par  <= 1'b0;
      de_d     <= 1'b0;
    end else begin
      de_d <= vid.de_in;
      if (fs) frc_frm <= frc_frm + 2'd1;
      if (fs)                           line_par <= 1'b0;
      else if (de_d && !vid.de_in)      line_par <= ~line_par;
      pix_par <= vid.de_in ? ~pix_par : 1'b0;
    end
  end
`else
  assign r_conv = vid.rdata_in[P_IN_BIT-1 -: P_OUT_BIT];
  assign g_conv = vid.gdata_in[P_IN_BIT-1 -: P_OUT_BIT];
  assign b_conv = vid.bdata_in[P_IN_BIT-1 -: P_OUT_BIT];
`endif

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      vs_d          <= 1'b0;
      vid.vs_out    <= 1'(P_VS_INV);
      vid.hs_out    <= 1'(P_HS_INV);
      vid.de_out    <= 1'b0;
      vid.rdata_out <= '0;
      vid.gdata_out <= '0;
      vid.bdata_out <= '0;
      ready         <= 1'b0;
      rev           <= 1'b0;
    end else begin
      vs_d          <= vid.vs_in;
      vid.vs_out    <= vid.vs_in ^ 1'(P_VS_INV);
      vid.hs_out    <= vid.hs_in ^ 1'(P_HS_INV);
      vid.de_out    <= vid.de_in & run_nx;
      vid.rdata_out <= run_nx ? r_conv : '0;
      vid.gdata_out <= run_nx ? g_conv : '0;
      vid.bdata_out <= run_nx ? b_conv : '0;
      ready         <= run_nx;
      if (!rev_en || xstby) rev <= 1'b0;
      else if (fs)          rev <= ~rev;
    end
  end

endmodule

// File: tb/tb_tg_pwrseq.sv
// Scoreboard bench for tg_pwrseq: stimulus pushes expected panel pixels, a monitor pops on de_out.
// Build with TG_FRC_DITHER_EN defined to exercise the dithering path as well.
module tb_tg_pwrseq;
  logic clk = 1'b0;
  logic xrst = 1'b0;
  logic pwr_req = 1'b0;
  logic rev_en = 1'b0;
  logic xstby, rev, ready;

  int n_tests = 0;
  int n_fail  = 0;
  logic [17:0] sb[$];

  logic [7:0] r_tab [4] = '{8'hA7, 8'h5C, 8'hFF, 8'h03};
  logic [7:0] g_tab [4] = '{8'hFD, 8'h06, 8'hA5, 8'h59};
  logic [7:0] b_tab [4] = '{8'h58, 8'hA3, 8'h00, 8'hFC};
  logic [5:0] r_exp [4] = '{6'h29, 6'h17, 6'h3F, 6'h00};
  logic [5:0] g_exp [4] = '{6'h3F, 6'h01, 6'h29, 6'h16};
  logic [5:0] b_exp [4] = '{6'h16, 6'h28, 6'h00, 6'h3F};

  tg_pwrseq_if #(.P_IN_BIT(8), .P_OUT_BIT(6)) vif ();

  tg_pwrseq #(
    .P_IN_BIT(8), .P_OUT_BIT(6), .P_WAIT_CNT(6250), .P_CNT_BIT(13),
    .P_BLANK_FRM(2), .P_VS_INV(1), .P_HS_INV(1)
  ) dut (
    .clk(clk), .xrst(xrst), .pwr_req(pwr_req), .rev_en(rev_en),
    .vid(vif), .xstby(xstby), .rev(rev), .ready(ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

`ifdef TG_FRC_DITHER_EN
  int   tb_frm = 0;
  logic tb_vs_q = 1'b0;
  always @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      tb_frm  = 0;
      tb_vs_q = 1'b0;
    end else begin
      if (vif.vs_in && !tb_vs_q) tb_frm = (tb_frm + 1) % 4;
      tb_vs_q = vif.vs_in;
    end
  end

  function automatic logic [5:0] dith(input logic [7:0] d, input int l, input int p);
    logic [1:0] t;
    logic [5:0] m;
    t = 2'(tb_frm + 2 * (l % 2) + (p % 2));
    m = d[7:2];
    if ((d[1:0] > t) && (m != 6'h3F)) m = m + 6'd1;
    return m;
  endfunction
`endif

  function automatic logic [17:0] exp_pix(input int l, input int p, input int mode);
`ifdef TG_FRC_DITHER_EN
    return {dith(vif.rdata_in, l, p), dith(vif.gdata_in, l, p), dith(vif.bdata_in, l, p)};
`else
    if (l < 0) return '0;
    case (mode)
      0:       return {r_exp[p], g_exp[p], b_exp[p]};
      1:       return {6'h01, 6'h01, 6'h01};
      default: return {6'h3F, 6'h3F, 6'h3F};
    endcase
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: act=%0h req=%0h", name, act, req);
    end
  endtask

  // Monitor: blank-state checks every cycle, scoreboard pop on every valid panel pixel.
  initial begin
    forever begin
      @(negedge clk);
      if (xrst) begin
        if (!ready) chk("blank", {vif.de_out, vif.rdata_out, vif.gdata_out, vif.bdata_out}, 32'h0);
        if (vif.de_out) begin
          if (sb.size() == 0) chk("sb_underflow", 32'h1, 32'h0);
          else chk("pixel", {vif.rdata_out, vif.gdata_out, vif.bdata_out}, sb.pop_front());
        end
      end
    end
  end

  task automatic set_pix(input int p, input int mode);
    case (mode)
      0: begin
        vif.rdata_in = r_tab[p]; vif.gdata_in = g_tab[p]; vif.bdata_in = b_tab[p];
      end
      1: begin
        vif.rdata_in = 8'h05; vif.gdata_in = 8'h05; vif.bdata_in = 8'h05;
      end
      default: begin
        vif.rdata_in = 8'hFF; vif.gdata_in = 8'hFF; vif.bdata_in = 8'hFF;
      end
    endcase
  endtask

  task automatic send_frame(input bit push, input int mode);
    vif.vs_in = 1'b1; tick(2);
    vif.vs_in = 1'b0; tick(2);
    for (int l = 0; l < 2; l++) begin
      vif.hs_in = 1'b1; tick(1);
      vif.hs_in = 1'b0; tick(1);
      for (int p = 0; p < 4; p++) begin
        set_pix(p, mode);
        vif.de_in = 1'b1;
        if (push) sb.push_back(exp_pix(l, p, mode));
        tick(1);
      end
      vif.de_in = 1'b0;
      tick(2);
    end
  endtask

  task automatic wait_xstby_low(output int n);
    n = 0;
    while (xstby && n < 7000) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    int bad;
    int n;
    vif.vs_in = 1'b0; vif.hs_in = 1'b0; vif.de_in = 1'b0;
    vif.rdata_in = 8'hA7; vif.gdata_in = 8'hA7; vif.bdata_in = 8'hA7;

    // Reset values
    tick(3);
    chk("rst_vs_out", 32'(vif.vs_out), 32'h1);
    chk("rst_hs_out", 32'(vif.hs_out), 32'h1);
    chk("rst_de_data", {vif.de_out, vif.rdata_out, vif.gdata_out, vif.bdata_out}, 32'h0);
    chk("rst_ctrl", {xstby, rev, ready}, 32'b100);
    xrst = 1'b1;

    // Idle with pwr_req low under live video
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      vif.vs_in = ((i % 50) < 2);
      vif.de_in = ((i % 10) > 4) && ((i % 50) > 4);
      tick(1);
      if (xstby !== 1'b1 || ready !== 1'b0 || rev !== 1'b0) bad++;
    end
    vif.vs_in = 1'b0; vif.de_in = 1'b0;
    chk("idle_ctrl", 32'(bad), 32'h0);

    // Abort during the standby wait
    pwr_req = 1'b1; tick(100);
    pwr_req = 1'b0; tick(6500);
    chk("abort_xstby", 32'(xstby), 32'h1);

    // Power-up timing and blank frames
    pwr_req = 1'b1;
    wait_xstby_low(n);
    chk("xstby_fall_clks", 32'(n), 32'd6251);
    chk("ready_after_wait", 32'(ready), 32'h0);
    send_frame(1'b0, 0);
    chk("ready_after_fs1", 32'(ready), 32'h0);
    send_frame(1'b1, 0);
    chk("ready_after_fs2", 32'(ready), 32'h1);
    chk("xstby_run", 32'(xstby), 32'h0);

    // Sync polarity in RUN
    vif.vs_in = 1'b1; vif.hs_in = 1'b1; tick(1);
    chk("vs_hs_active", {vif.vs_out, vif.hs_out}, 32'b00);
    vif.vs_in = 1'b0; vif.hs_in = 1'b0; tick(1);
    chk("vs_hs_idle", {vif.vs_out, vif.hs_out}, 32'b11);
    tick(5);

    // REV toggling
    rev_en = 1'b1; tick(1);
    chk("rev_en_no_fs", 32'(rev), 32'h0);
    for (int k = 0; k < 5; k++) begin
      send_frame(1'b1, 0);
      chk("rev_frame", 32'(rev), 32'((k % 2) == 0));
    end
    rev_en = 1'b0; tick(1);
    chk("rev_disable", 32'(rev), 32'h0);

`ifdef TG_FRC_DITHER_EN
    // Dither over four frames, then saturation
    repeat (4) send_frame(1'b1, 1);
    send_frame(1'b1, 2);
`endif

    // Power-down: immediate blank, re-request ignored, xstby high on 2nd fs
    set_pix(0, 0);
    vif.de_in = 1'b1; pwr_req = 1'b0; tick(1);
    vif.de_in = 1'b0;
    chk("down_de_gate", {vif.de_out, ready}, 32'b00);
    tick(2);
    pwr_req = 1'b1; tick(3);
    send_frame(1'b0, 0);
    chk("down_fs1_xstby", {xstby, ready}, 32'b00);
    send_frame(1'b0, 0);
    chk("down_fs2_xstby", 32'(xstby), 32'h1);

    // Second power-up, then async reset mid-run
    wait_xstby_low(n);
    chk("repower_xstby", 32'(xstby), 32'h0);
    send_frame(1'b0, 0);
    send_frame(1'b1, 0);
    chk("repower_ready", 32'(ready), 32'h1);
    #3 xrst = 1'b0;
    #1;
    chk("async_rst", {xstby, ready, vif.de_out}, 32'b100);
    tick(2);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
